// File: rtl/rtc_bcd_hms.sv
// rtc_bcd_hms: BCD hours/minutes/seconds real-time clock with prescaler,
// run/pause, validated time-load handshake and 12h/24h mode.
// Optional alarm compare is built when RTC_ALARM_EN is defined.
module rtc_bcd_hms #(
  parameter int TICK_DIV = 100000,
  parameter int H12_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        set_valid,
  input  logic [23:0] set_hms,
  input  logic        set_pm,
  output logic        set_ack,
  output logic        set_err,
  output logic [3:0]  hora_d,
  output logic [3:0]  hora_u,
  output logic [3:0]  min_d,
  output logic [3:0]  min_u,
  output logic [3:0]  seg_d,
  output logic [3:0]  seg_u,
  output logic        pm,
  output logic        sec_tick,
  output logic        min_tick
`ifdef RTC_ALARM_EN
  ,
  input  logic        alarm_set,
  input  logic [15:0] alarm_hm,
  input  logic        alarm_pm,
  input  logic        alarm_on,
  input  logic        alarm_clr,
  output logic        alarm_fire
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [23:0] RESET_HMS = (H12_MODE != 0) ? 24'h120000 : 24'h000000;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} ld_state_t;

  ld_state_t     state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [23:0]   hms_q;
  logic          pm_q;
  logic [23:0]   ld_hms;
  logic          ld_pm;
  logic [24:0]   nxt;
  logic          wrap, ld_ok, commit, advance_sec, sec59;
  logic          ack_d, err_d;

  // One-second advance of a BCD time value; bit 24 carries the pm flag.
  function automatic logic [24:0] advance(input logic [23:0] t, input logic p);
    logic [3:0] hd, hu, md, mu, sd, su;
    logic np;
    {hd, hu, md, mu, sd, su} = t;
    np = p;
    if (su != 4'd9) su = su + 4'd1;
    else begin
      su = 4'd0;
      if (sd != 4'd5) sd = sd + 4'd1;
      else begin
        sd = 4'd0;
        if (mu != 4'd9) mu = mu + 4'd1;
        else begin
          mu = 4'd0;
          if (md != 4'd5) md = md + 4'd1;
          else begin
            md = 4'd0;
            if (H12_MODE != 0) begin
              if (hd == 4'd1 && hu == 4'd1) begin
                hu = 4'd2;
                np = ~np;
              end else if (hd == 4'd1 && hu == 4'd2) begin
                hd = 4'd0;
                hu = 4'd1;
              end else if (hu == 4'd9) begin
                hd = 4'd1;
                hu = 4'd0;
              end else hu = hu + 4'd1;
            end else begin
              if (hd == 4'd2 && hu == 4'd3) begin
                hd = 4'd0;
                hu = 4'd0;
              end else if (hu == 4'd9) begin
                hd = hd + 4'd1;
                hu = 4'd0;
              end else hu = hu + 4'd1;
            end
          end
        end
      end
    end
    return {np, hd, hu, md, mu, sd, su};
  endfunction

  // Range check of a load value for the configured hour mode.
  function automatic logic hms_legal(input logic [23:0] v);
    logic [3:0] hd, hu, md, mu, sd, su;
    logic ok;
    {hd, hu, md, mu, sd, su} = v;
    ok = (hu <= 4'd9) && (md <= 4'd5) && (mu <= 4'd9) && (sd <= 4'd5) && (su <= 4'd9);
    if (H12_MODE != 0) ok = ok && ((hd == 4'd0 && hu != 4'd0) || (hd == 4'd1 && hu <= 4'd2));
    else               ok = ok && ((hd <= 4'd1) || (hd == 4'd2 && hu <= 4'd3));
    return ok;
  endfunction

  assign wrap        = run && (presc_q == PRE_LAST);
  assign ld_ok       = hms_legal(ld_hms);
  assign commit      = (state_q == S_CHECK) && ld_ok;
  assign advance_sec = wrap && !commit;
  assign sec59       = (hms_q[7:0] == 8'h59);
  assign nxt         = advance(hms_q, pm_q);

  // Load handshake state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Load handshake next state and accept/reject decision.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE:  if (set_valid) state_d = S_CHECK;
      S_CHECK: begin
        ack_d   = ld_ok;
        err_d   = !ld_ok;
        state_d = S_WAIT;
      end
      S_WAIT:  if (!set_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the requested load value when a request is first seen.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && set_valid) begin
      ld_hms <= set_hms;
      ld_pm  <= set_pm;
    end
  end

  // Prescaler: counts while running, restarts on a committed load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     presc_q <= '0;
    else if (commit) presc_q <= '0;
    else if (run)    presc_q <= wrap ? '0 : presc_q + PW'(1);
  end

  // Time registers and strobes; a committed load overrides a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hms_q    <= RESET_HMS;
      pm_q     <= 1'b0;
      set_ack  <= 1'b0;
      set_err  <= 1'b0;
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
    end else begin
      set_ack  <= ack_d;
      set_err  <= err_d;
      sec_tick <= advance_sec;
      min_tick <= advance_sec && sec59;
      if (commit) begin
        hms_q <= ld_hms;
        pm_q  <= (H12_MODE != 0) ? ld_pm : 1'b0;
      end else if (advance_sec) begin
        hms_q <= nxt[23:0];
        pm_q  <= nxt[24];
      end
    end
  end

  assign {hora_d, hora_u, min_d, min_u, seg_d, seg_u} = hms_q;
  assign pm = pm_q;

`ifdef RTC_ALARM_EN
  logic [15:0] alarm_hm_q;
  logic        alarm_pm_q;
  logic        fire_q;

  // Alarm register and fire flag; clear or disable beats a new match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hm_q <= 16'h0000;
      alarm_pm_q <= 1'b0;
      fire_q     <= 1'b0;
    end else begin
      if (alarm_set) begin
        alarm_hm_q <= alarm_hm;
        alarm_pm_q <= alarm_pm;
      end
      if (alarm_clr || !alarm_on) fire_q <= 1'b0;
      else if (advance_sec && sec59 && (nxt[23:8] == alarm_hm_q) &&
               ((H12_MODE == 0) || (nxt[24] == alarm_pm_q)))
        fire_q <= 1'b1;
    end
  end

  assign alarm_fire = fire_q;
`endif

endmodule

// File: tb/tb_rtc_bcd_hms.sv
// Bench for rtc_bcd_hms: a 24h and a 12h instance share stimulus and are
// compared against a seconds-of-day reference model.
`timescale 1ns/1ps
module tb_rtc_bcd_hms;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] set_hms = 24'h0;
  logic        set_pm = 1'b0;

  logic ack_24, err_24, pm_24, sec_24, min_24;
  logic ack_12, err_12, pm_12, sec_12, min_12;
  logic [3:0] hd_24, hu_24, md_24, mu_24, sd_24, su_24;
  logic [3:0] hd_12, hu_12, md_12, mu_12, sd_12, su_12;

`ifdef RTC_ALARM_EN
  logic        alarm_set = 1'b0, alarm_pm = 1'b0, alarm_on = 1'b0, alarm_clr = 1'b0;
  logic [15:0] alarm_hm = 16'h0;
  logic        fire_24, fire_12;
`endif

  always #5 clk = ~clk;

  rtc_bcd_hms #(.TICK_DIV(TD), .H12_MODE(0)) dut24 (
    .clk(clk), .reset(reset), .run(run), .set_valid(set_valid), .set_hms(set_hms),
    .set_pm(set_pm), .set_ack(ack_24), .set_err(err_24), .hora_d(hd_24), .hora_u(hu_24),
    .min_d(md_24), .min_u(mu_24), .seg_d(sd_24), .seg_u(su_24), .pm(pm_24),
    .sec_tick(sec_24), .min_tick(min_24)
`ifdef RTC_ALARM_EN
    , .alarm_set(alarm_set), .alarm_hm(alarm_hm), .alarm_pm(alarm_pm),
    .alarm_on(alarm_on), .alarm_clr(alarm_clr), .alarm_fire(fire_24)
`endif
  );

  rtc_bcd_hms #(.TICK_DIV(TD), .H12_MODE(1)) dut12 (
    .clk(clk), .reset(reset), .run(run), .set_valid(set_valid), .set_hms(set_hms),
    .set_pm(set_pm), .set_ack(ack_12), .set_err(err_12), .hora_d(hd_12), .hora_u(hu_12),
    .min_d(md_12), .min_u(mu_12), .seg_d(sd_12), .seg_u(su_12), .pm(pm_12),
    .sec_tick(sec_12), .min_tick(min_12)
`ifdef RTC_ALARM_EN
    , .alarm_set(alarm_set), .alarm_hm(alarm_hm), .alarm_pm(alarm_pm),
    .alarm_on(alarm_on), .alarm_clr(alarm_clr), .alarm_fire(fire_12)
`endif
  );

  logic [23:0] hms24, hms12;
  logic [28:0] obs24, obs12;
  assign hms24 = {hd_24, hu_24, md_24, mu_24, sd_24, su_24};
  assign hms12 = {hd_12, hu_12, md_12, mu_12, sd_12, su_12};
  assign obs24 = {pm_24, hms24, ack_24, err_24, sec_24, min_24};
  assign obs12 = {pm_12, hms12, ack_12, err_12, sec_12, min_12};

  int total = 0;
  int bad = 0;
  int n_ack24, n_err24, n_ack12, n_err12;

  // ---------------- reference model (index 0: 24h, 1: 12h) ----------------
  int          secs[2] = '{0, 0};
  int          cnt[2] = '{0, 0};
  bit          e_ack[2], e_err[2], e_sec[2], e_min[2];
  int          phase = 0;
  logic [23:0] cap = 24'h0;
  logic        cap_pm = 1'b0;

  function automatic bit legal(input logic [23:0] v, input int m);
    int hd, hu, md, mu, sd, su, h;
    hd = int'(v[23:20]); hu = int'(v[19:16]); md = int'(v[15:12]);
    mu = int'(v[11:8]);  sd = int'(v[7:4]);   su = int'(v[3:0]);
    if (hu > 9 || mu > 9 || su > 9 || md > 5 || sd > 5 || hd > 9) return 1'b0;
    h = hd * 10 + hu;
    if (m == 0) return h <= 23;
    return (h >= 1) && (h <= 12);
  endfunction

  function automatic int hms2secs(input logic [23:0] v, input logic p, input int m);
    int h;
    h = int'(v[23:20]) * 10 + int'(v[19:16]);
    if (m == 1) h = (h % 12) + (p ? 12 : 0);
    return h * 3600 + (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [24:0] exp_time(input int s, input int m);
    int h, mi, se;
    logic p;
    h = s / 3600; mi = (s / 60) % 60; se = s % 60; p = 1'b0;
    if (m == 1) begin
      p = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {p, 4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic logic [28:0] exp_vec(input int m);
    return {exp_time(secs[m], m), e_ack[m], e_err[m], e_sec[m], e_min[m]};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      phase <= 0;
      for (int m = 0; m < 2; m++) begin
        secs[m] <= 0; cnt[m] <= 0;
        e_ack[m] <= 1'b0; e_err[m] <= 1'b0; e_sec[m] <= 1'b0; e_min[m] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        e_ack[m] <= (phase == 1) && legal(cap, m);
        e_err[m] <= (phase == 1) && !legal(cap, m);
        if (phase == 1 && legal(cap, m)) begin
          secs[m] <= hms2secs(cap, cap_pm, m);
          cnt[m] <= 0; e_sec[m] <= 1'b0; e_min[m] <= 1'b0;
        end else if (run && cnt[m] == TD - 1) begin
          cnt[m] <= 0;
          secs[m] <= (secs[m] + 1) % 86400;
          e_sec[m] <= 1'b1;
          e_min[m] <= (secs[m] % 60 == 59);
        end else begin
          if (run) cnt[m] <= cnt[m] + 1;
          e_sec[m] <= 1'b0; e_min[m] <= 1'b0;
        end
      end
      case (phase)
        0: if (set_valid) begin cap <= set_hms; cap_pm <= set_pm; phase <= 1; end
        1: phase <= 2;
        default: if (!set_valid) phase <= 0;
      endcase
    end
  end

  // ---------------- tasks ----------------
  task automatic do_load(input logic [23:0] v, input logic p, input int hold, input string name);
    n_ack24 = 0; n_err24 = 0; n_ack12 = 0; n_err12 = 0;
    set_hms = v; set_pm = p; set_valid = 1'b1;
    for (int i = 0; i < hold + 2; i++) begin
      if (i == hold) set_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      n_ack24 += int'(ack_24); n_err24 += int'(err_24);
      n_ack12 += int'(ack_12); n_err12 += int'(err_12);
      total++;
      if (obs24 !== exp_vec(0)) begin bad++; $display("FAIL %s 24h: got %h want %h", name, obs24, exp_vec(0)); end
      total++;
      if (obs12 !== exp_vec(1)) begin bad++; $display("FAIL %s 12h: got %h want %h", name, obs12, exp_vec(1)); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs24 !== 29'h0) begin bad++; $display("FAIL reset_24h: got %h want %h", obs24, 29'h0); end
    total++;
    if (obs12 !== {1'b0, 24'h120000, 4'h0}) begin
      bad++; $display("FAIL reset_12h: got %h want %h", obs12, {1'b0, 24'h120000, 4'h0});
    end
    reset = 1'b1;
  endtask

  task automatic test_first_second();
    for (int i = 0; i < TD; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (obs24 !== exp_vec(0)) begin bad++; $display("FAIL first_sec 24h: got %h want %h", obs24, exp_vec(0)); end
      total++;
      if (obs12 !== exp_vec(1)) begin bad++; $display("FAIL first_sec 12h: got %h want %h", obs12, exp_vec(1)); end
    end
    total++;
    if ({su_24, sec_24, min_24} !== 6'b0001_1_0) begin
      bad++; $display("FAIL first_sec_tick: got su=%0d sec=%b min=%b want su=1 sec=1 min=0", su_24, sec_24, min_24);
    end
  endtask

  task automatic test_rollover();
    bit saw_min;
    run = 1'b0;
    do_load(24'h235958, 1'b0, 3, "load_235958");
    total++;
    if ({n_ack24, n_err24, n_ack12, n_err12} !== {32'd1, 32'd0, 32'd0, 32'd1}) begin
      bad++; $display("FAIL rollover_ack: got ack24=%0d err24=%0d ack12=%0d err12=%0d want 1 0 0 1",
                      n_ack24, n_err24, n_ack12, n_err12);
    end
    run = 1'b1; saw_min = 1'b0;
    for (int i = 0; i < 2 * TD; i++) begin
      @(posedge clk); @(negedge clk);
      if (i < 2 * TD - 1) saw_min |= min_24;
      total++;
      if (obs24 !== exp_vec(0)) begin bad++; $display("FAIL rollover 24h: got %h want %h", obs24, exp_vec(0)); end
      total++;
      if (obs12 !== exp_vec(1)) begin bad++; $display("FAIL rollover 12h: got %h want %h", obs12, exp_vec(1)); end
    end
    total++;
    if ({hms24, sec_24, min_24, saw_min} !== {24'h000000, 3'b110}) begin
      bad++; $display("FAIL rollover_wrap: got %h sec=%b min=%b early_min=%b want 000000 1 1 0",
                      hms24, sec_24, min_24, saw_min);
    end
  endtask

  task automatic test_12h();
    run = 1'b0;
    do_load(24'h115959, 1'b0, 2, "load_115959");
    run = 1'b1;
    repeat (TD) @(posedge clk);
    @(negedge clk);
    total++;
    if ({pm_12, hms12, pm_24, hms24} !== {1'b1, 24'h120000, 1'b0, 24'h120000}) begin
      bad++; $display("FAIL noon: got 12h %b %h 24h %b %h want 1 120000 0 120000", pm_12, hms12, pm_24, hms24);
    end
    run = 1'b0;
    do_load(24'h125959, 1'b1, 2, "load_125959");
    run = 1'b1;
    repeat (TD) @(posedge clk);
    @(negedge clk);
    total++;
    if ({pm_12, hms12, pm_24, hms24} !== {1'b1, 24'h010000, 1'b0, 24'h130000}) begin
      bad++; $display("FAIL one_pm: got 12h %b %h 24h %b %h want 1 010000 0 130000", pm_12, hms12, pm_24, hms24);
    end
  endtask

  task automatic test_illegal();
    run = 1'b0;
    do_load(24'h240000, 1'b0, 5, "load_240000");
    total++;
    if ({n_ack24, n_err24, n_ack12, n_err12} !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
      bad++; $display("FAIL hour24_err: got ack24=%0d err24=%0d ack12=%0d err12=%0d want 0 1 0 1",
                      n_ack24, n_err24, n_ack12, n_err12);
    end
    total++;
    if (hms24 !== 24'h130000) begin bad++; $display("FAIL hour24_keep: got %h want 130000", hms24); end
    do_load(24'h000060, 1'b0, 2, "load_sd6");
    total++;
    if ({n_err24, n_ack24, hms24} !== {32'd1, 32'd0, 24'h130000}) begin
      bad++; $display("FAIL sd6_err: got err=%0d ack=%0d time=%h want 1 0 130000", n_err24, n_ack24, hms24);
    end
  endtask

  task automatic test_load_on_wrap();
    bit found;
    run = 1'b1; found = 1'b0;
    for (int i = 0; i < 2 * TD && !found; i++) begin
      @(posedge clk); @(negedge clk);
      found = (cnt[0] == TD - 2);
    end
    total++;
    if (!found) begin bad++; $display("FAIL wrap_align: got no prescaler alignment want count %0d", TD - 2); end
    set_hms = 24'h102030; set_pm = 1'b0; set_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (obs24 !== exp_vec(0)) begin bad++; $display("FAIL wrap_load 24h: got %h want %h", obs24, exp_vec(0)); end
      total++;
      if (obs12 !== exp_vec(1)) begin bad++; $display("FAIL wrap_load 12h: got %h want %h", obs12, exp_vec(1)); end
    end
    total++;
    if ({hms24, ack_24, sec_24} !== {24'h102030, 2'b10}) begin
      bad++; $display("FAIL wrap_commit: got %h ack=%b sec=%b want 102030 1 0", hms24, ack_24, sec_24);
    end
    set_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_pause();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({hms24, sec_24} !== {24'h102030, 1'b0}) begin
        bad++; $display("FAIL pause: got %h sec=%b want 102030 0", hms24, sec_24);
      end
    end
  endtask

  task automatic test_reset_mid_check();
    run = 1'b0; set_hms = 24'h050505; set_pm = 1'b0; set_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({ack_24, err_24, hms24, ack_12, hms12, pm_12} !== {2'b00, 24'h000000, 1'b0, 24'h120000, 1'b0}) begin
      bad++; $display("FAIL reset_mid: got ack=%b err=%b %h / ack=%b %h pm=%b want 0 0 000000 / 0 120000 0",
                      ack_24, err_24, hms24, ack_12, hms12, pm_12);
    end
    set_valid = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (obs24 !== exp_vec(0)) begin bad++; $display("FAIL post_reset 24h: got %h want %h", obs24, exp_vec(0)); end
      total++;
      if (obs12 !== exp_vec(1)) begin bad++; $display("FAIL post_reset 12h: got %h want %h", obs12, exp_vec(1)); end
    end
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (obs24 !== exp_vec(0)) begin bad++; $display("FAIL random 24h cyc %0d: got %h want %h", i, obs24, exp_vec(0)); end
      total++;
      if (obs12 !== exp_vec(1)) begin bad++; $display("FAIL random 12h cyc %0d: got %h want %h", i, obs12, exp_vec(1)); end
      run = ($urandom % 4) != 0;
      if (left > 0) begin
        left--;
        if (left == 0) set_valid = 1'b0;
      end else if ($urandom % 10 == 0) begin
        if ($urandom % 4 == 0) set_hms = 24'($urandom);
        else set_hms = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        set_pm = 1'($urandom);
        set_valid = 1'b1;
        left = $urandom_range(1, 5);
      end
    end
    set_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

`ifdef RTC_ALARM_EN
  task automatic test_alarm();
    run = 1'b0; alarm_hm = 16'h0001; alarm_pm = 1'b0; alarm_set = 1'b1; alarm_on = 1'b1;
    @(posedge clk); @(negedge clk);
    alarm_set = 1'b0;
    do_load(24'h000059, 1'b0, 2, "load_000059");
    run = 1'b1;
    repeat (TD) @(posedge clk);
    @(negedge clk);
    total++;
    if ({fire_24, hms24} !== {1'b1, 24'h000100}) begin
      bad++; $display("FAIL alarm_fire: got %b %h want 1 000100", fire_24, hms24);
    end
    alarm_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    alarm_clr = 1'b0;
    total++;
    if (fire_24 !== 1'b0) begin bad++; $display("FAIL alarm_clr: got %b want 0", fire_24); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_second();
    test_rollover();
    test_12h();
    test_illegal();
    test_load_on_wrap();
    test_pause();
    test_reset_mid_check();
    test_random();
`ifdef RTC_ALARM_EN
    test_alarm();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
